// File: rtl/wb_bridge_pkg.sv
// Shared decode offsets, FSM encoding and register bit positions for the
// Wishbone-to-core bridge.
package wb_bridge_pkg;

   localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
   localparam logic [31:0] CSR_BASE   = 32'h0000_1000;
   localparam logic [31:0] CSR_CTRL   = 32'h0000_1000;
   localparam logic [31:0] CSR_STATUS = 32'h0000_1004;
   localparam logic [31:0] CSR_PC     = 32'h0000_1008;
   localparam logic [31:0] CSR_CYCLES = 32'h0000_100C;
   localparam logic [31:0] CSR_IRQ    = 32'h0000_1010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_RD = 2'd1,
      ACK    = 2'd2
   } wb_state_t;

   localparam int CTRL_RUN      = 0;
   localparam int CTRL_CORE_EN  = 1;
   localparam int ST_HALTED     = 0;
   localparam int ST_RUN        = 1;
   localparam int ST_WR_BLOCKED = 2;
   localparam int IRQ_HALT      = 0;

endpackage

// File: rtl/wb_bridge_csr.sv
// Control/status registers: core run/enable, sticky blocked-write flag,
// run-cycle counter and halt interrupt. Writes arrive pre-qualified by sel[0].
module wb_bridge_csr
   import wb_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_wr_vld,
   input  logic [4:0]  i_wr_addr,
   input  logic [2:0]  i_wr_dat,
   input  logic [4:0]  i_rd_addr,
   output logic [31:0] o_rd_dat,
   input  logic        i_blk_set,
   input  logic [31:0] i_core_pc,
   input  logic        i_core_halted,
   output logic        o_core_rst_n,
   output logic        o_core_run,
   output logic        o_irq
);

   logic        r_run;
   logic        r_core_en;
   logic        r_blocked;
   logic        r_irq;
   logic        r_halt_d;
   logic [31:0] r_cycles;

   logic w_wr_ctrl;
   logic w_wr_status;
   logic w_wr_cycles;
   logic w_wr_irq;
   logic w_halt_rise;

   assign w_wr_ctrl   = i_wr_vld && (i_wr_addr == CSR_CTRL[4:0]);
   assign w_wr_status = i_wr_vld && (i_wr_addr == CSR_STATUS[4:0]);
   assign w_wr_cycles = i_wr_vld && (i_wr_addr == CSR_CYCLES[4:0]);
   assign w_wr_irq    = i_wr_vld && (i_wr_addr == CSR_IRQ[4:0]);
   assign w_halt_rise = i_core_halted && !r_halt_d;

   assign o_core_run   = r_run & r_core_en;
   assign o_core_rst_n = r_core_en;
   assign o_irq        = r_irq;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run     <= 1'b0;
         r_core_en <= 1'b0;
         r_blocked <= 1'b0;
         r_irq     <= 1'b0;
         r_halt_d  <= 1'b0;
         r_cycles  <= '0;
      end else begin
         r_halt_d <= i_core_halted;
         if (w_wr_ctrl) begin
            r_run     <= i_wr_dat[CTRL_RUN];
            r_core_en <= i_wr_dat[CTRL_CORE_EN];
         end
         if (i_blk_set)
            r_blocked <= 1'b1;
         else if (w_wr_status && i_wr_dat[ST_WR_BLOCKED])
            r_blocked <= 1'b0;
         // Clear has priority over the run increment in the same cycle.
         if (w_wr_cycles)
            r_cycles <= '0;
         else if (o_core_run)
            r_cycles <= r_cycles + 32'd1;
         // A new halt edge beats a simultaneous W1C.
         if (w_halt_rise)
            r_irq <= 1'b1;
         else if (w_wr_irq && i_wr_dat[IRQ_HALT])
            r_irq <= 1'b0;
      end
   end

   always_comb begin
      o_rd_dat = '0;
      case (i_rd_addr)
         CSR_CTRL[4:0]: begin
            o_rd_dat[CTRL_RUN]     = r_run;
            o_rd_dat[CTRL_CORE_EN] = r_core_en;
         end
         CSR_STATUS[4:0]: begin
            o_rd_dat[ST_HALTED]     = i_core_halted;
            o_rd_dat[ST_RUN]        = r_run;
            o_rd_dat[ST_WR_BLOCKED] = r_blocked;
         end
         CSR_PC[4:0]:     o_rd_dat = i_core_pc;
         CSR_CYCLES[4:0]: o_rd_dat = r_cycles;
         CSR_IRQ[4:0]:    o_rd_dat[IRQ_HALT] = r_irq;
         default:         o_rd_dat = '0;
      endcase
   end

endmodule

// File: rtl/wb_cpu_bridge.sv
// Wishbone classic slave giving firmware an IMEM window and core control CSRs.
// Ack latency 1 for writes/CSR reads, 2 for IMEM reads; no error responses.
module wb_cpu_bridge
   import wb_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          IMEM_WORDS = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wbs_stb_i,
   input  logic                          wbs_cyc_i,
   input  logic                          wbs_we_i,
   input  logic [3:0]                    wbs_sel_i,
   input  logic [31:0]                   wbs_dat_i,
   input  logic [31:0]                   wbs_adr_i,
   output logic                          wbs_ack_o,
   output logic [31:0]                   wbs_dat_o,
   output logic                          imem_we_o,
   output logic [3:0]                    imem_wmask_o,
   output logic [$clog2(IMEM_WORDS)-1:0] imem_addr_o,
   output logic [31:0]                   imem_wdata_o,
   input  logic [31:0]                   imem_rdata_i,
   output logic                          core_rst_n_o,
   output logic                          core_run_o,
   input  logic [31:0]                   core_pc_i,
   input  logic                          core_halted_i,
   output logic                          irq_o
);

   localparam int          AW         = $clog2(IMEM_WORDS);
   localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_WORDS);

   wb_state_t   r_state;
   wb_state_t   w_state_nxt;
   logic [31:0] r_dat;
   logic        r_csr_wr;
   logic [4:0]  r_wr_addr;
   logic [2:0]  r_wr_dat;

   logic [31:0] w_offset;
   logic [31:0] w_imem_off;
   logic        w_hit;
   logic        w_req;
   logic        w_is_imem;
   logic        w_is_csr;
   logic        w_blk_set;
   logic [31:0] w_csr_rd;

   assign w_offset   = wbs_adr_i - BASE_ADDR;
   assign w_imem_off = w_offset - IMEM_BASE;
   assign w_hit      = (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
   // Gating with rst_n keeps the combinational IMEM port quiet during reset.
   assign w_req      = rst_n && wbs_stb_i && wbs_cyc_i && w_hit;
   assign w_is_imem  = (w_imem_off < IMEM_BYTES);
   assign w_is_csr   = (w_offset[31:5] == CSR_BASE[31:5]);

   assign wbs_ack_o = (r_state == ACK);
   assign wbs_dat_o = wbs_ack_o ? r_dat : 32'd0;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      imem_we_o    = 1'b0;
      imem_addr_o  = '0;
      imem_wdata_o = '0;
      imem_wmask_o = '0;
      w_blk_set    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_state_nxt = ACK;
               if (w_is_imem) begin
                  imem_addr_o = w_imem_off[AW+1:2];
                  if (wbs_we_i) begin
                     imem_wdata_o = wbs_dat_i;
                     imem_wmask_o = wbs_sel_i;
                     if (core_run_o)
                        w_blk_set = 1'b1;
                     else
                        imem_we_o = 1'b1;
                  end else begin
                     w_state_nxt = MEM_RD;
                  end
               end
            end
         end
         MEM_RD:  w_state_nxt = wbs_cyc_i ? ACK : IDLE;
         ACK:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // CSR writes are held until the ack cycle so core_run_o moves as it ends.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dat     <= '0;
         r_csr_wr  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_dat  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_dat     <= (!wbs_we_i && w_is_csr) ? w_csr_rd : 32'd0;
                  r_csr_wr  <= wbs_we_i && wbs_sel_i[0] && w_is_csr;
                  r_wr_addr <= w_offset[4:0];
                  r_wr_dat  <= wbs_dat_i[2:0];
               end
            end
            MEM_RD:  r_dat <= imem_rdata_i;
            ACK:     r_csr_wr <= 1'b0;
            default: r_csr_wr <= 1'b0;
         endcase
      end
   end

   wb_bridge_csr u_csr (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_wr_vld      (wbs_ack_o && r_csr_wr),
      .i_wr_addr     (r_wr_addr),
      .i_wr_dat      (r_wr_dat),
      .i_rd_addr     (w_offset[4:0]),
      .o_rd_dat      (w_csr_rd),
      .i_blk_set     (w_blk_set),
      .i_core_pc     (core_pc_i),
      .i_core_halted (core_halted_i),
      .o_core_rst_n  (core_rst_n_o),
      .o_core_run    (core_run_o),
      .o_irq         (irq_o)
   );

endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Directed bench for wb_cpu_bridge with a behavioural IMEM and immediate assertions.
module tb_wb_cpu_bridge;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i, wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        imem_we_o;
   logic [3:0]  imem_wmask_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_wdata_o;
   logic [31:0] imem_rdata_i;
   logic        core_rst_n_o, core_run_o;
   logic [31:0] core_pc_i;
   logic        core_halted_i;
   logic        irq_o;

   always #5 clk = ~clk;

   wb_cpu_bridge #(.BASE_ADDR(BASE), .IMEM_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .imem_we_o(imem_we_o), .imem_wmask_o(imem_wmask_o), .imem_addr_o(imem_addr_o),
      .imem_wdata_o(imem_wdata_o), .imem_rdata_i(imem_rdata_i),
      .core_rst_n_o(core_rst_n_o), .core_run_o(core_run_o),
      .core_pc_i(core_pc_i), .core_halted_i(core_halted_i), .irq_o(irq_o)
   );

   // Synchronous-read instruction memory.
   bit [31:0] mem [256];
   always @(posedge clk) begin
      if (imem_we_o)
         for (int b = 0; b < 4; b++)
            if (imem_wmask_o[b]) mem[imem_addr_o][8*b +: 8] <= imem_wdata_o[8*b +: 8];
      imem_rdata_i <= mem[imem_addr_o];
   end

   int          we_cnt = 0;
   logic [7:0]  we_addr;
   logic [3:0]  we_mask;
   logic [31:0] we_data;
   always @(negedge clk) begin
      if (imem_we_o) begin
         we_cnt  = we_cnt + 1;
         we_addr = imem_addr_o;
         we_mask = imem_wmask_o;
         we_data = imem_wdata_o;
      end
   end

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Starts at #1 after an edge with the FSM idle; returns at #1 after the
   // edge following the ack cycle (or after the budget expires).
   task automatic wb_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input int budget,
                         output logic [31:0] rdat, output int lat);
      int n;
      wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      lat = -1; rdat = 32'hFFFF_FFFF; n = 0;
      while (lat < 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (wbs_ack_o) begin
            lat  = n;
            rdat = wbs_dat_o;
         end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   logic [31:0] rd;
   int          lat;
   int          we_before;

   initial begin
      rst_n = 1'b0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_dat_i = '0; wbs_adr_i = '0;
      core_pc_i = 32'h0000_1234; core_halted_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack_dat_we", {wbs_ack_o, imem_we_o, wbs_dat_o[29:0]}, 32'h0);
      check("rst_imem_port", {imem_addr_o, imem_wmask_o, imem_wdata_o[19:0]}, 32'h0);
      check("rst_core", {29'd0, core_rst_n_o, core_run_o, irq_o}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      wb_txn(BASE + 32'h0, 1'b1, 32'hDEAD_BEEF, 4'hF, 8, rd, lat);
      check("imem_wr_lat", lat, 1);
      check("imem_wr_pulses", we_cnt, 1);
      check("imem_wr_addr_mask", {we_addr, we_mask}, {8'd0, 4'hF});
      check("imem_wr_data", we_data, 32'hDEAD_BEEF);
      wb_txn(BASE + 32'h0, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("imem_rd_lat", lat, 2);
      check("imem_rd_data", rd, 32'hDEAD_BEEF);
      wb_txn(BASE + 32'h4, 1'b1, 32'h1122_3344, 4'h3, 8, rd, lat);
      check("imem_wr1_addr_mask", {we_addr, we_mask}, {8'd1, 4'h3});
      wb_txn(BASE + 32'h4, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("imem_rd1_masked", rd, 32'h0000_3344);

      wb_txn(BASE + 32'h100C, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("cycles_idle", rd, 32'h0);
      wb_txn(BASE + 32'h1008, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("pc_read", rd, 32'h0000_1234);
      check("csr_rd_lat", lat, 1);

      wb_txn(BASE + 32'h1000, 1'b1, 32'h3, 4'h1, 8, rd, lat);
      check("ctrl_core_out", {30'd0, core_rst_n_o, core_run_o}, 32'h3);
      repeat (10) begin @(posedge clk); #1; end
      wb_txn(BASE + 32'h100C, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("cycles_in_range", {31'd0, (rd >= 32'd10 && rd <= 32'd12)}, 32'h1);
      wb_txn(BASE + 32'h100C, 1'b1, 32'h0, 4'hF, 8, rd, lat);
      wb_txn(BASE + 32'h100C, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("cycles_cleared", {31'd0, (rd <= 32'd2)}, 32'h1);
      wb_txn(BASE + 32'h1000, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("ctrl_read", rd, 32'h3);

      we_before = we_cnt;
      wb_txn(BASE + 32'h8, 1'b1, 32'hCAFE_F00D, 4'hF, 8, rd, lat);
      check("blocked_wr_lat", lat, 1);
      check("blocked_wr_no_pulse", we_cnt, we_before);
      wb_txn(BASE + 32'h1004, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("status_blocked", rd, 32'h6);
      wb_txn(BASE + 32'h1004, 1'b1, 32'h4, 4'hF, 8, rd, lat);
      wb_txn(BASE + 32'h1004, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("status_cleared", rd, 32'h2);
      wb_txn(BASE + 32'h8, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("blocked_mem_untouched", rd, 32'h0);

      core_halted_i = 1'b1;
      @(posedge clk); #1;
      check("irq_on_halt", irq_o, 1);
      core_halted_i = 1'b0;
      @(posedge clk); #1;
      // W1C commits at the end of the ack cycle, coinciding with a new halt edge.
      wbs_adr_i = BASE + 32'h1010; wbs_we_i = 1'b1; wbs_dat_i = 32'h1; wbs_sel_i = 4'hF;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      @(posedge clk); #1;
      check("irq_w1c_ack", wbs_ack_o, 1);
      core_halted_i = 1'b1;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      @(posedge clk); #1;
      check("irq_set_wins", irq_o, 1);
      wb_txn(BASE + 32'h1010, 1'b1, 32'h1, 4'hF, 8, rd, lat);
      check("irq_w1c_clears", irq_o, 0);
      wb_txn(BASE + 32'h1004, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("status_halted", rd, 32'h3);
      core_halted_i = 1'b0;

      wb_txn(BASE + 32'h2000, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("unmapped_lat", lat, 1);
      check("unmapped_data", rd, 32'h0);
      wb_txn(32'h3100_0000, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("foreign_no_ack", lat, -1);

      wbs_adr_i = BASE; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_ack_dat", {wbs_ack_o, wbs_dat_o[30:0]}, 32'h0);
      check("midrst_imem_port", {imem_we_o, imem_addr_o, imem_wmask_o, imem_wdata_o[18:0]}, 32'h0);
      check("midrst_core", {29'd0, core_rst_n_o, core_run_o, irq_o}, 32'h0);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      wb_txn(BASE + 32'h0, 1'b0, 32'h0, 4'hF, 8, rd, lat);
      check("post_rst_rd_lat", lat, 2);
      check("post_rst_rd_data", rd, 32'hDEAD_BEEF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
